// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and state encoding for the pipe_stage_reg pipeline register.
package pipe_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 3;
    localparam int PIPE_TAG_W  = 5;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    // Bit 0 is "main slot valid" and bit 1 is "skid slot valid".
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int TAG_W  = PIPE_TAG_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_ctrl, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, out_tag
    );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One valid+payload storage slot; clear wins over load and zeroes the payload.
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with 2-entry skid buffer, flush and bubble squash.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt/bubble_cnt counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int TAG_W  = PIPE_TAG_W
) (
    input  logic        clk,
    input  logic        clrn,
    pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    localparam int PAY_W = DATA_W + CTRL_W + TAG_W;

    if (DATA_W < 1 || CTRL_W < 1 || TAG_W < 1) begin : g_bad_width
        $error("pipe_stage_reg: DATA_W, CTRL_W and TAG_W must all be at least 1");
    end

    state_t             state;
    state_t             next_state;
    logic               main_load, main_clear, main_from_skid;
    logic               skid_load, skid_clear;
    logic               main_valid, skid_valid;
    logic [PAY_W-1:0]   main_q, skid_q, main_d, in_pay;
    logic               in_xfer, out_xfer;

    assign in_pay   = {bus.in_data, bus.in_ctrl, bus.in_tag};
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = main_valid && bus.out_ready;
    assign main_d   = main_from_skid ? skid_q : in_pay;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_EMPTY;
        else       state <= next_state;
    end

    // Flush overrides every transition; the skid entry always drains into main before new data.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush) begin
            next_state = S_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_load  = 1'b1;
                        next_state = S_FULL;
                    end
                end
                S_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load  = 1'b1;
                        next_state = S_SKID;
                    end else if (out_xfer) begin
                        main_clear = 1'b1;
                        next_state = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        next_state     = S_FULL;
                    end
                end
                default: begin
                    next_state = S_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk   (clk),
        .clrn  (clrn),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pay),
        .valid (skid_valid),
        .q     (skid_q)
    );

    // Control and tag are squashed so a bubble can never write memory or the register file.
    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_q[PAY_W-1 -: DATA_W];
    assign bus.out_ctrl  = main_valid ? main_q[TAG_W +: CTRL_W] : '0;
    assign bus.out_tag   = main_valid ? main_q[TAG_W-1:0] : '0;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_hit, bubble_hit;

    // A flush of a non-empty stage always has out_valid=1, so both bubble sources never coincide.
    assign stall_hit  = main_valid && !bus.out_ready;
    assign bubble_hit = (!main_valid && bus.out_ready) || (bus.flush && state != S_EMPTY);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_hit && stall_cnt != 32'hFFFF_FFFF)   stall_cnt  <= stall_cnt + 32'd1;
            if (bubble_hit && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default widths 64/3/5).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk  = 1'b0;
    logic clrn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(3), .TAG_W(5)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .TAG_W(5)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .bus        (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ctrl   = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic [2:0] c, input logic [4:0] t);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_ctrl  = c;
        bus.in_tag   = t;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        clrn = 1'b0;
        #2;
        @(negedge clk);
        clrn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        clrn = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_ctrl !== 3'd0 ||
            bus.out_tag !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b data=%h ctrl=%b tag=%0d rdy=%b, want 0/0/0/0/1",
                     bus.out_valid, bus.out_data, bus.out_ctrl, bus.out_tag, bus.in_ready);
        end
        @(negedge clk);
        clrn = 1'b1;
        step();
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(64'(i), 3'b001, 5'(i));
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 64'(i) || bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_%0d: valid=%b data=%0d rdy=%b, want 1/%0d/1",
                         i, bus.out_valid, bus.out_data, bus.in_ready, i);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 3'd0) begin
            errors++;
            $display("[TB] FAIL stream_drain: valid=%b ctrl=%b, want 0/000", bus.out_valid, bus.out_ctrl);
        end
    endtask

    task automatic test_back_pressure();
        bus.out_ready = 1'b0;
        push(64'hAAAA, 3'b010, 5'd10);
        step();
        push(64'hBBBB, 3'b100, 5'd11);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 64'hAAAA) begin
            errors++;
            $display("[TB] FAIL bp_skid: rdy=%b data=%h, want 0/aaaa", bus.in_ready, bus.out_data);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hAAAA || bus.out_tag !== 5'd10) begin
            errors++;
            $display("[TB] FAIL bp_hold: valid=%b data=%h tag=%0d, want 1/aaaa/10",
                     bus.out_valid, bus.out_data, bus.out_tag);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hBBBB || bus.out_ctrl !== 3'b100 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second: valid=%b data=%h ctrl=%b rdy=%b, want 1/bbbb/100/1",
                     bus.out_valid, bus.out_data, bus.out_ctrl, bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        push(64'hA, 3'b111, 5'd1);
        step();
        push(64'hB, 3'b111, 5'd2);
        step();
        push(64'hC, 3'b111, 5'd3);
        bus.flush = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 3'd0 || bus.out_tag !== 5'd0 ||
            bus.out_data !== 64'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_skid: valid=%b data=%h ctrl=%b tag=%0d rdy=%b, want 0/0/0/0/1",
                     bus.out_valid, bus.out_data, bus.out_ctrl, bus.out_tag, bus.in_ready);
        end
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_no_c_%0d: valid=%b data=%h, want 0", i, bus.out_valid, bus.out_data);
            end
        end
    endtask

    task automatic test_squash();
        bus.out_ready = 1'b1;
        push(64'h55, 3'b111, 5'd7);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 3'b111 || bus.out_tag !== 5'd7) begin
            errors++;
            $display("[TB] FAIL squash_live: valid=%b ctrl=%b tag=%0d, want 1/111/7",
                     bus.out_valid, bus.out_ctrl, bus.out_tag);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 3'd0 || bus.out_tag !== 5'd0) begin
            errors++;
            $display("[TB] FAIL squash_bubble: valid=%b ctrl=%b tag=%0d, want 0/000/0",
                     bus.out_valid, bus.out_ctrl, bus.out_tag);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push(64'h1234, 3'b011, 5'd4);
        step();
        push(64'h5678, 3'b101, 5'd5);
        step();
        bus.in_valid = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_ctrl !== 3'd0 ||
            bus.out_tag !== 5'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset: valid=%b data=%h ctrl=%b tag=%0d rdy=%b, want 0/0/0/0/1",
                     bus.out_valid, bus.out_data, bus.out_ctrl, bus.out_tag, bus.in_ready);
        end
        @(negedge clk);
        clrn = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_release: valid=%b rdy=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.out_ready = 1'b0;
        push(64'h99, 3'b001, 5'd9);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_stall: stall=%0d bubble=%0d, want 5/0", stall_cnt, bubble_cnt);
        end
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        step();
        checks++;
        if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL perf_bubble: stall=%0d bubble=%0d, want 5/3", stall_cnt, bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_squash();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
